hack_alu_pipe: RTL and testbench

Two-stage pipelined 16-bit Hack ALU that consumes operand words and produces the Hack ALU result plus `zr`/`ng` flags. It sits directly downstream of the 16-bit bitwise gate layer (Nand16/And16/Not16). It builds the `x&y` path from Nand16 followed by inversion, and the `x+y` path from a 16-bit adder. A valid/ready handshake on both sides lets the CPU datapath stall it without losing or duplicating results.

---
 rtl/hack_alu_pipe_if.sv | 23 ++
 rtl/hack_alu_pipe.sv | 59 +++++
 tb/tb_hack_alu_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hack_alu_pipe_if.sv
// hack_alu_pipe_if: operand/result bus with valid/ready handshake on both sides
interface hack_alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [5:0]       ctrl;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out;
   logic             zr;
   logic             ng;
   logic             out_valid;
   logic             out_ready;
   modport master (
      output x, y, ctrl, in_valid, out_ready,
      input  in_ready, out, zr, ng, out_valid
   );
   modport slave (
      input  x, y, ctrl, in_valid, out_ready,
      output in_ready, out, zr, ng, out_valid
   );
endinterface

// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage valid/ready pipelined Hack ALU producing out, zr and ng
module hack_alu_pipe #(
   parameter int WIDTH = 16
) (
   input logic            clk,
   input logic            rst_n,
   hack_alu_pipe_if.slave bus
);
   typedef enum logic [1:0] {EMPTY = 2'b00, S1 = 2'b01, S2 = 2'b10, BOTH = 2'b11} state_e;
   state_e           state_q, state_d;
   logic             v1, v2, adv2, in_ready;
   logic [WIDTH-1:0] xa, ya, xb_d, yb_d, xb_q, yb_q, r, o_d, out_q;
   logic             f_q, no_q, zr_q, ng_q;
   assign v1       = state_q[0];
   assign v2       = state_q[1];
   assign adv2     = !v2 || bus.out_ready;
   assign in_ready = !v1 || adv2;
   assign xa       = bus.ctrl[5] ? '0 : bus.x;
   assign xb_d     = bus.ctrl[4] ? ~xa : xa;
   assign ya       = bus.ctrl[3] ? '0 : bus.y;
   assign yb_d     = bus.ctrl[2] ? ~ya : ya;
   // x&y is taken as an inverted NAND to mirror the gate layer upstream
   assign r        = f_q ? xb_q + yb_q : ~(~(xb_q & yb_q));
   assign o_d      = no_q ? ~r : r;
   always_comb begin
      state_d = state_e'({adv2 ? v1 : v2, in_ready ? bus.in_valid : v1});
   end
   always_ff @(posedge clk) begin
      state_q <= !rst_n ? EMPTY : state_d;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xb_q  <= '0;
         yb_q  <= '0;
         f_q   <= 1'b0;
         no_q  <= 1'b0;
         out_q <= '0;
         zr_q  <= 1'b1;
         ng_q  <= 1'b0;
      end else begin
         if (in_ready) begin
            xb_q <= xb_d;
            yb_q <= yb_d;
            f_q  <= bus.ctrl[1];
            no_q <= bus.ctrl[0];
         end
         if (adv2) begin
            out_q <= o_d;
            zr_q  <= o_d == '0;
            ng_q  <= o_d[WIDTH-1];
         end
      end
   end
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = v2;
   assign bus.out       = out_q;
   assign bus.zr        = zr_q;
   assign bus.ng        = ng_q;
endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb_hack_alu_pipe: table-driven vectors plus handshake sequences for hack_alu_pipe
module tb_hack_alu_pipe;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   hack_alu_pipe_if bus ();
   hack_alu_pipe dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [5:0]  ctrl;
      logic [15:0] o;
      logic        zr;
      logic        ng;
   } vec_t;
   vec_t vecs [12];
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [5:0] c, input logic ordy);
      bus.in_valid  = v;
      bus.x         = x;
      bus.y         = y;
      bus.ctrl      = c;
      bus.out_ready = ordy;
   endtask
   // n inputs x=x0+k with out=x, consumer stalled for the first `stall` cycles
   task automatic stream(input string tag, input int n, input int stall, input logic [15:0] x0);
      int sent = 0;
      int got = 0;
      int extra = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         drive(sent < n, x0 + 16'(sent), 16'h0000, 6'b001100, c >= stall);
         @(negedge clk);
         if (c >= 2 && c < stall) begin
            chk({tag, " in_ready stalled"}, 16'(bus.in_ready), 16'h0000);
            chk({tag, " out held"}, bus.out, x0);
            chk({tag, " accepted while full"}, 16'(sent), 16'd2);
         end
         if (c == stall && n > 2) begin
            chk({tag, " simul in_ready"}, 16'(bus.in_ready), 16'h0001);
            chk({tag, " simul out_valid"}, 16'(bus.out_valid), 16'h0001);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (got < n) chk({tag, " order"}, bus.out, x0 + 16'(got));
            else extra++;
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
      end
      chk({tag, " inputs accepted"}, 16'(sent), 16'(n));
      chk({tag, " results"}, 16'(got), 16'(n));
      chk({tag, " duplicates"}, 16'(extra), 16'h0000);
   endtask
   initial begin
      int stale;
      checks   = 0;
      failures = 0;
      vecs[0]  = '{16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0};
      vecs[1]  = '{16'h0005, 16'h0003, 6'b010011, 16'h0002, 1'b0, 1'b0};
      vecs[2]  = '{16'h0005, 16'h0003, 6'b000000, 16'h0001, 1'b0, 1'b0};
      vecs[3]  = '{16'h0005, 16'h0003, 6'b101010, 16'h0000, 1'b1, 1'b0};
      vecs[4]  = '{16'h0005, 16'h0003, 6'b111111, 16'h0001, 1'b0, 1'b0};
      vecs[5]  = '{16'h0005, 16'h0003, 6'b111010, 16'hFFFF, 1'b0, 1'b1};
      vecs[6]  = '{16'h3CC3, 16'h0FF0, 6'b000000, 16'h0CC0, 1'b0, 1'b0};
      vecs[7]  = '{16'hAAAA, 16'h5555, 6'b000000, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1};
      vecs[9]  = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0};
      vecs[10] = '{16'h1234, 16'h9999, 6'b001100, 16'h1234, 1'b0, 1'b0};
      vecs[11] = '{16'hABCD, 16'h00F0, 6'b110001, 16'hFF0F, 1'b0, 1'b1};
      rst_n = 1'b0;
      drive(1'b1, 16'h1111, 16'h2222, 6'b000010, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1);
      @(negedge clk);
      chk("reset out_valid", 16'(bus.out_valid), 16'h0000);
      chk("reset in_ready", 16'(bus.in_ready), 16'h0001);
      chk("reset out", bus.out, 16'h0000);
      chk("reset zr", 16'(bus.zr), 16'h0001);
      chk("reset ng", 16'(bus.ng), 16'h0000);
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         #1;
         if (k < 12) drive(1'b1, vecs[k].x, vecs[k].y, vecs[k].ctrl, 1'b1);
         else drive(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1);
         @(negedge clk);
         chk($sformatf("vec%0d in_ready", k), 16'(bus.in_ready), 16'h0001);
         if (k >= 2) begin
            chk($sformatf("vec%0d out_valid", k - 2), 16'(bus.out_valid), 16'h0001);
            chk($sformatf("vec%0d out", k - 2), bus.out, vecs[k-2].o);
            chk($sformatf("vec%0d zr", k - 2), 16'(bus.zr), 16'(vecs[k-2].zr));
            chk($sformatf("vec%0d ng", k - 2), 16'(bus.ng), 16'(vecs[k-2].ng));
         end
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("drained out_valid", 16'(bus.out_valid), 16'h0000);
      stream("backpressure", 5, 4, 16'h0001);
      stream("simultaneous", 3, 2, 16'h0010);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         drive(k < 2, 16'h0055 + 16'(k), 16'h0000, 6'b001100, 1'b0);
      end
      @(negedge clk);
      chk("pre-reset full", 16'(bus.in_ready), 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(1'b1, 16'h0077, 16'h0000, 6'b001100, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1);
      @(negedge clk);
      chk("midreset out_valid", 16'(bus.out_valid), 16'h0000);
      chk("midreset out", bus.out, 16'h0000);
      chk("midreset zr", 16'(bus.zr), 16'h0001);
      chk("midreset in_ready", 16'(bus.in_ready), 16'h0001);
      stale = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("midreset stale results", 16'(stale), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
